// File: rtl/pe_mac_param_if.sv
// pe_mac_param_if: operand, control and drain-chain bundle for one processing element
interface pe_mac_param_if #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 20
);
    logic                iValid;
    logic [DATA_W-1:0]   iData;
    logic [WEIGHT_W-1:0] iWeight;
    logic                iClearAcc;
    logic                iDrain;
    logic                iChainValid;
    logic [ACC_W-1:0]    iChainAcc;
    logic                oValid;
    logic [DATA_W-1:0]   oData;
    logic [WEIGHT_W-1:0] oWeight;
    logic                oClearAcc;
    logic                oDrain;
    logic [ACC_W-1:0]    oAcc;
    logic                oOverflow;
    logic                oChainValid;
    logic [ACC_W-1:0]    oChainAcc;

    modport master (
        output iValid, iData, iWeight, iClearAcc, iDrain, iChainValid, iChainAcc,
        input  oValid, oData, oWeight, oClearAcc, oDrain, oAcc, oOverflow, oChainValid, oChainAcc
    );

    modport slave (
        input  iValid, iData, iWeight, iClearAcc, iDrain, iChainValid, iChainAcc,
        output oValid, oData, oWeight, oClearAcc, oDrain, oAcc, oOverflow, oChainValid, oChainAcc
    );
endinterface

// File: rtl/pe_mac_param.sv
// pe_mac_param: parametrised systolic MAC element with tagged multiplier pipeline and drain chain
module pe_mac_param #(
    parameter int DATA_W   = 8,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 20,
    parameter int MULT_LAT = 1,
    parameter int SIGNED   = 0,
    parameter int SATURATE = 1
) (
    input logic           iClk,
    input logic           iRstN,
    pe_mac_param_if.slave bus
);
    localparam int PW = DATA_W + WEIGHT_W;
    localparam bit S  = SIGNED != 0;

    logic [PW-1:0]    w_dx, w_wx, w_prod, w_xprod;
    logic [2:0]       w_xtag;
    logic [ACC_W:0]   w_pext, w_aext, w_sum;
    logic             w_ovf, w_ovf_nxt;
    logic [ACC_W-1:0] w_sat, w_acc_nxt;
    logic [ACC_W-1:0] r_acc, r_chain_acc;
    logic             r_ovf, r_chain_v, r_valid, r_clear, r_drain;
    logic [DATA_W-1:0]   r_data;
    logic [WEIGHT_W-1:0] r_weight;

    // Operands widened to the product width so one multiply is exact in both modes
    assign w_dx   = {{WEIGHT_W{S & bus.iData[DATA_W-1]}}, bus.iData};
    assign w_wx   = {{DATA_W{S & bus.iWeight[WEIGHT_W-1]}}, bus.iWeight};
    assign w_prod = w_dx * w_wx;

    // Tags are {valid, clear, drain}
    if (MULT_LAT == 0) begin : g_comb
        assign w_xtag  = {bus.iValid, bus.iClearAcc, bus.iDrain};
        assign w_xprod = w_prod;
    end else begin : g_pipe
        logic [PW-1:0] r_prod [MULT_LAT];
        logic [2:0]    r_tag  [MULT_LAT];
        // Tags advance every cycle; a product moves only alongside a valid tag
        always_ff @(posedge iClk or negedge iRstN) begin
            if (!iRstN) begin
                for (int k = 0; k < MULT_LAT; k++) begin
                    r_prod[k] <= '0;
                    r_tag[k]  <= '0;
                end
            end else begin
                r_tag[0] <= {bus.iValid, bus.iClearAcc, bus.iDrain};
                if (bus.iValid) r_prod[0] <= w_prod;
                for (int k = 1; k < MULT_LAT; k++) begin
                    r_tag[k] <= r_tag[k-1];
                    if (r_tag[k-1][2]) r_prod[k] <= r_prod[k-1];
                end
            end
        end
        assign w_xtag  = r_tag[MULT_LAT-1];
        assign w_xprod = r_prod[MULT_LAT-1];
    end

    // One guard bit above the accumulator exposes overflow in either mode
    assign w_pext = {{(ACC_W+1-PW){S & w_xprod[PW-1]}}, w_xprod};
    assign w_aext = {S & r_acc[ACC_W-1], r_acc};
    assign w_sum  = w_aext + w_pext;
    assign w_ovf  = S ? (w_sum[ACC_W] ^ w_sum[ACC_W-1]) : w_sum[ACC_W];
    assign w_sat  = S ? {w_sum[ACC_W], {(ACC_W-1){~w_sum[ACC_W]}}} : '1;

    // Accumulator update at the exit slot: clear starts a new tile with this slot's product
    always_comb begin
        w_acc_nxt = r_acc;
        w_ovf_nxt = r_ovf;
        if (w_xtag[1]) begin
            w_acc_nxt = w_xtag[2] ? w_pext[ACC_W-1:0] : '0;
            w_ovf_nxt = 1'b0;
        end else if (w_xtag[2]) begin
            w_acc_nxt = (w_ovf && SATURATE != 0) ? w_sat : w_sum[ACC_W-1:0];
            w_ovf_nxt = r_ovf | w_ovf;
        end
    end

    // Neighbour forwarding, accumulator commit, and drain snapshot overriding the chain shift
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_valid     <= 1'b0;
            r_data      <= '0;
            r_weight    <= '0;
            r_clear     <= 1'b0;
            r_drain     <= 1'b0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_chain_v   <= 1'b0;
            r_chain_acc <= '0;
        end else begin
            r_valid     <= bus.iValid;
            r_data      <= bus.iData;
            r_weight    <= bus.iWeight;
            r_clear     <= bus.iClearAcc;
            r_drain     <= bus.iDrain;
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_chain_v   <= w_xtag[0] | bus.iChainValid;
            r_chain_acc <= w_xtag[0] ? r_acc : bus.iChainAcc;
        end
    end

    assign bus.oValid      = r_valid;
    assign bus.oData       = r_data;
    assign bus.oWeight     = r_weight;
    assign bus.oClearAcc   = r_clear;
    assign bus.oDrain      = r_drain;
    assign bus.oAcc        = r_acc;
    assign bus.oOverflow   = r_ovf;
    assign bus.oChainValid = r_chain_v;
    assign bus.oChainAcc   = r_chain_acc;
endmodule

// File: tb/tb_pe_mac_param.sv
// tb_pe_mac_param: three PE configurations driven in lockstep against an arithmetic reference model
module tb_pe_mac_param;
    logic iClk = 1'b0;
    logic iRstN = 1'b0;
    always #5 iClk = ~iClk;

    typedef struct packed {logic v; logic c; logic d; logic [7:0] a; logic [7:0] b;} slot_t;

    slot_t       cur, fwd;
    slot_t       hist[$];
    logic        cv;
    logic [19:0] ca;

    int lat [3] = '{1, 2, 0};
    int aw  [3] = '{20, 16, 16};
    bit sg  [3] = '{0, 0, 1};
    bit sat [3] = '{1, 1, 0};

    longint macc [3];
    bit     movf [3];
    bit     mcv  [3];
    longint mca  [3];
    int     checks = 0;
    int     errors = 0;

    pe_mac_param_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(20)) ifA ();
    pe_mac_param_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16)) ifB ();
    pe_mac_param_if #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16)) ifC ();

    pe_mac_param #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(20), .MULT_LAT(1), .SIGNED(0), .SATURATE(1))
        dutA (.iClk(iClk), .iRstN(iRstN), .bus(ifA.slave));
    pe_mac_param #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .MULT_LAT(2), .SIGNED(0), .SATURATE(1))
        dutB (.iClk(iClk), .iRstN(iRstN), .bus(ifB.slave));
    pe_mac_param #(.DATA_W(8), .WEIGHT_W(8), .ACC_W(16), .MULT_LAT(0), .SIGNED(1), .SATURATE(0))
        dutC (.iClk(iClk), .iRstN(iRstN), .bus(ifC.slave));

    assign {ifA.iValid, ifA.iClearAcc, ifA.iDrain, ifA.iData, ifA.iWeight} = cur;
    assign {ifB.iValid, ifB.iClearAcc, ifB.iDrain, ifB.iData, ifB.iWeight} = cur;
    assign {ifC.iValid, ifC.iClearAcc, ifC.iDrain, ifC.iData, ifC.iWeight} = cur;
    assign ifA.iChainValid = cv;
    assign ifB.iChainValid = cv;
    assign ifC.iChainValid = cv;
    assign ifA.iChainAcc   = ca;
    assign ifB.iChainAcc   = ca[15:0];
    assign ifC.iChainAcc   = ca[15:0];

    logic [63:0] oacc [3];
    logic [63:0] oca  [3];
    logic        oovf [3];
    logic        ocv  [3];
    logic [18:0] ofwd [3];
    assign oacc[0] = 64'(ifA.oAcc);
    assign oacc[1] = 64'(ifB.oAcc);
    assign oacc[2] = 64'(ifC.oAcc);
    assign oca[0]  = 64'(ifA.oChainAcc);
    assign oca[1]  = 64'(ifB.oChainAcc);
    assign oca[2]  = 64'(ifC.oChainAcc);
    assign oovf[0] = ifA.oOverflow;
    assign oovf[1] = ifB.oOverflow;
    assign oovf[2] = ifC.oOverflow;
    assign ocv[0]  = ifA.oChainValid;
    assign ocv[1]  = ifB.oChainValid;
    assign ocv[2]  = ifC.oChainValid;
    assign ofwd[0] = {ifA.oValid, ifA.oClearAcc, ifA.oDrain, ifA.oData, ifA.oWeight};
    assign ofwd[1] = {ifB.oValid, ifB.oClearAcc, ifB.oDrain, ifB.oData, ifB.oWeight};
    assign ofwd[2] = {ifC.oValid, ifC.oClearAcc, ifC.oDrain, ifC.oData, ifC.oWeight};

    function automatic longint msk(input int k);
        return (longint'(1) << aw[k]) - 1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            macc[k] = 0;
            movf[k] = 0;
            mcv[k]  = 0;
            mca[k]  = 0;
        end
        hist.delete();
        fwd = '0;
    endtask

    // One clock edge of configuration k, from the arithmetic rules of the element
    task automatic model(input int k);
        slot_t  s;
        longint m, lo, hi, old, da, dw, p, sum, w;
        int     idx;
        idx = hist.size() - 1 - lat[k];
        s = '0;
        if (idx >= 0) s = hist[idx];
        m   = msk(k);
        lo  = sg[k] ? -(longint'(1) << (aw[k] - 1)) : 0;
        hi  = sg[k] ? (longint'(1) << (aw[k] - 1)) - 1 : m;
        old = macc[k];
        mcv[k] = s.d ? 1'b1 : cv;
        mca[k] = s.d ? (old & m) : (longint'(ca) & m);
        da  = sg[k] ? longint'($signed(s.a)) : longint'(s.a);
        dw  = sg[k] ? longint'($signed(s.b)) : longint'(s.b);
        p   = da * dw;
        sum = old + p;
        if (s.c) begin
            macc[k] = s.v ? p : 0;
            movf[k] = 0;
        end else if (s.v) begin
            if (sum > hi || sum < lo) begin
                movf[k] = 1;
                w = sum & m;
                if (sg[k] && w > hi) w = w - (m + 1);
                macc[k] = sat[k] ? ((sum > hi) ? hi : lo) : w;
            end else begin
                macc[k] = sum;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("acc%0d", k), oacc[k], macc[k] & msk(k));
            chk($sformatf("ovf%0d", k), 64'(oovf[k]), 64'(movf[k]));
            chk($sformatf("chainv%0d", k), 64'(ocv[k]), 64'(mcv[k]));
            chk($sformatf("chaina%0d", k), oca[k], mca[k]);
            chk($sformatf("fwd%0d", k), 64'(ofwd[k]), 64'(fwd));
        end
    endtask

    task automatic drive(input logic v, c, d, input logic [7:0] a, b, input logic chv, input logic [19:0] cha);
        cur = '{v, c, d, a, b};
        cv  = chv;
        ca  = cha;
    endtask

    task automatic step();
        hist.push_back(cur);
        if (hist.size() > 8) void'(hist.pop_front());
        @(posedge iClk);
        for (int k = 0; k < 3; k++) model(k);
        fwd = cur;
        #1;
        check_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge iClk);
        #1;
        iRstN = 1'b1;
        check_all();

        drive(1, 1, 0, 3, 4, 0, 0);   step();
        drive(1, 0, 0, 5, 6, 0, 0);   step(); chk("A.mac12", oacc[0], 12);
        drive(1, 0, 0, 2, 10, 0, 0);  step(); chk("A.mac42", oacc[0], 42);
        drive(1, 1, 1, 1, 1, 0, 0);   step(); chk("A.mac62", oacc[0], 62);
        drive(0, 0, 0, 0, 0, 0, 0);   step();
        chk("A.drainv", 64'(ocv[0]), 1);
        chk("A.draina", oca[0], 62);
        chk("A.newtile", oacc[0], 1);

        drive(1, 1, 0, 255, 255, 0, 0); step();
        drive(1, 0, 0, 255, 255, 0, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0);     step(); chk("B.sat1", oacc[1], 65025);
        step();
        chk("B.sat2", oacc[1], 65535);
        chk("B.ovf", 64'(oovf[1]), 1);
        drive(0, 1, 0, 0, 0, 0, 0);     step();
        drive(0, 0, 0, 0, 0, 0, 0);     step(); step();
        chk("B.ovfclr", 64'(oovf[1]), 0);

        drive(1, 1, 0, 8'h80, 8'h80, 0, 0); step(); chk("C.sq", oacc[2], 64'h4000);
        drive(1, 0, 0, 8'h80, 8'h80, 0, 0); step(); step();
        chk("C.wrap", oacc[2], 64'hC000);
        chk("C.ovf", 64'(oovf[2]), 1);
        drive(1, 1, 0, 8'hFD, 8'h05, 0, 0); step(); chk("C.neg15", oacc[2], 64'hFFF1);

        drive(0, 0, 0, 0, 0, 0, 0); step(); step(); step();
        drive(0, 0, 0, 0, 0, 1, 20'h00ABC); step();
        chk("A.chain", oca[0], 64'h00ABC);
        chk("A.chainv", 64'(ocv[0]), 1);
        drive(0, 0, 1, 0, 0, 1, 20'h12345); step();
        chk("C.collide", oca[2], 64'hFFF1);
        drive(0, 0, 0, 0, 0, 0, 0); step(); step(); step();

        for (int i = 0; i < 5; i++) begin
            drive(1, i == 0, 0, 8'($urandom), 8'($urandom), 0, 0);
            step();
        end
        #2;
        iRstN = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("rst%0d", k), {oacc[k][19:0], oca[k][19:0], oovf[k], ocv[k], ofwd[k]}, 0);
        model_reset();
        @(posedge iClk);
        #1;
        iRstN = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        step(); step(); step();
        chk("B.nostale", oacc[1], 0);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                  8'($urandom), 8'($urandom), $urandom_range(0, 1) == 1, 20'($urandom));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
